// File: rtl/uart_fifo_bridge.sv
// Byte-command bridge between a UART byte interface and a word FIFO.
// Commands: 'W' push word, 'R' pop word, 'S' status byte, 'C' flush; all answered over tx.
module uart_fifo_bridge #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int BYTES      = DATA_W / 8,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          tx_busy,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          rx_drop
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {IDLE, RX_WORD, PUSH, POP, TX_SEND, TX_GAP, TX_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [3:0]        bcnt_reg, bcnt_next;
  logic [3:0]        left_reg, left_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              full_reg, empty_reg, flush_reg, flush_next;
  logic              tx_start_reg, tx_start_next, rx_drop_reg, rx_drop_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;
  logic              mem_we;
  logic              load_resp;
  logic [DATA_W-1:0] resp_word;
  logic [3:0]        resp_n;
  logic [5:0]        status_cnt;
  logic [7:0]        status_byte;

  function automatic logic [DATA_W-1:0] byte_word(input logic [7:0] b);
    return DATA_W'(b) << (DATA_W - 8);
  endfunction

  // Free-running registered read keeps the head word ready for POP one cycle later.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr_reg] <= shift_reg;
    rd_data_reg <= mem[rd_ptr_reg];
  end

  always_comb begin
    status_cnt = (int'(count_reg) > 63) ? 6'd63 : 6'(count_reg);
    status_byte = {full_reg, empty_reg, status_cnt};
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bcnt_next     = bcnt_reg;
    left_next     = left_reg;
    timer_next    = timer_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    flush_next    = flush_reg;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    rx_drop_next  = rx_valid && (state_reg != IDLE) && (state_reg != RX_WORD);
    mem_we        = 1'b0;
    load_resp     = 1'b0;
    resp_word     = '0;
    resp_n        = 4'd1;

    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_W: begin
              state_next = RX_WORD;
              bcnt_next  = '0;
              timer_next = '0;
            end
            CMD_R: begin
              if (empty_reg) begin
                load_resp = 1'b1;
                resp_word = byte_word(NAK);
              end else begin
                state_next = POP;
              end
            end
            CMD_S: begin
              load_resp = 1'b1;
              resp_word = byte_word(status_byte);
            end
            CMD_C: begin
              load_resp  = 1'b1;
              resp_word  = byte_word(ACK);
              flush_next = 1'b1;
            end
            default: begin
              load_resp = 1'b1;
              resp_word = byte_word(NAK);
            end
          endcase
        end
      end
      RX_WORD: begin
        if (rx_valid) begin
          shift_next = (shift_reg << 8) | DATA_W'(rx_data);
          timer_next = '0;
          if (bcnt_reg == 4'(BYTES - 1))
            state_next = PUSH;
          else
            bcnt_next = bcnt_reg + 4'd1;
        end else if (timer_reg == TW'(TIMEOUT_CYC - 1)) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      PUSH: begin
        load_resp = 1'b1;
        if (full_reg) begin
          resp_word = byte_word(NAK);
        end else begin
          resp_word   = byte_word(ACK);
          mem_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + AW'(1);
          count_next  = count_reg + CW'(1);
        end
      end
      POP: begin
        load_resp   = 1'b1;
        resp_word   = rd_data_reg;
        resp_n      = 4'(BYTES);
        rd_ptr_next = rd_ptr_reg + AW'(1);
        count_next  = count_reg - CW'(1);
      end
      TX_SEND: begin
        state_next = TX_GAP;
        // Flush lands after the ACK is issued so the count drops a cycle later.
        if (flush_reg) begin
          wr_ptr_next = '0;
          rd_ptr_next = '0;
          count_next  = '0;
          flush_next  = 1'b0;
        end
      end
      TX_GAP: state_next = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) begin
          if (left_reg == 4'd0) begin
            state_next = IDLE;
          end else begin
            load_resp = 1'b1;
            resp_word = shift_reg;
            resp_n    = left_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Response bytes go out MSB first; a busy transmitter parks the word in TX_WAIT.
    if (load_resp) begin
      if (tx_busy) begin
        shift_next = resp_word;
        left_next  = resp_n;
        state_next = TX_WAIT;
      end else begin
        tx_start_next = 1'b1;
        tx_data_next  = resp_word[DATA_W-1 -: 8];
        shift_next    = resp_word << 8;
        left_next     = resp_n - 4'd1;
        state_next    = TX_SEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bcnt_reg     <= '0;
      left_reg     <= '0;
      timer_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      flush_reg    <= 1'b0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
      rx_drop_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bcnt_reg     <= bcnt_next;
      left_reg     <= left_next;
      timer_reg    <= timer_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      full_reg     <= (count_next == CW'(DEPTH));
      empty_reg    <= (count_next == '0);
      flush_reg    <= flush_next;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
      rx_drop_reg  <= rx_drop_next;
    end
  end

  assign tx_start   = tx_start_reg;
  assign tx_data    = tx_data_reg;
  assign fifo_count = count_reg;
  assign fifo_full  = full_reg;
  assign fifo_empty = empty_reg;
  assign rx_drop    = rx_drop_reg;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench for uart_fifo_bridge: expected tx bytes are queued at stimulus time,
// a negedge monitor pops and compares on every tx_start.
module tb_uart_fifo_bridge;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int TMO    = 40;
  localparam int CW     = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          rx_drop;

  int tests = 0;
  int fails = 0;
  int drop_cnt = 0;
  int busy_cnt = 0;
  int d0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  uart_fifo_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for six cycles starting the cycle after tx_start.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tx_unexpected: got 0x%02h, required no byte", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_data !== mon_exp) begin
            fails++;
            $display("FAIL tx_byte: got 0x%02h, required 0x%02h", tx_data, mon_exp);
          end else begin
            $display("[TB] tx byte 0x%02h ok", tx_data);
          end
        end
      end
      if (rx_drop) drop_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int k = 0;
    while (exp_q.size() > n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      tests++;
      fails++;
      $display("FAIL wait_q_timeout: got %0d pending bytes, required %0d", exp_q.size(), n);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || tx_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      tests++;
      fails++;
      $display("FAIL response_timeout: got %0d pending bytes, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  task automatic push_w(input logic [15:0] w, input logic [7:0] resp);
    exp_q.push_back(resp);
    send_byte(8'h57);
    idle(2);
    send_byte(w[15:8]);
    idle(2);
    send_byte(w[7:0]);
    wait_done();
  endtask

  task automatic read_w(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    send_byte(8'h52);
    wait_done();
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", fifo_full, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_rx_drop", rx_drop, 0);
    rst = 1'b0;
    idle(2);

    // Single write then read, with latency checks.
    exp_q.push_back(8'h06);
    send_byte(8'h57); idle(2); send_byte(8'h12); idle(2); send_byte(8'h34);
    check("w_count_n1", fifo_count, 0);
    check("w_start_n1", tx_start, 0);
    @(negedge clk);
    check("w_count_n2", fifo_count, 1);
    check("w_start_n2", tx_start, 1);
    check("w_empty", fifo_empty, 0);
    wait_done();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_byte(8'h52);
    check("r_start_n1", tx_start, 0);
    check("r_count_n1", fifo_count, 1);
    @(negedge clk);
    check("r_start_n2", tx_start, 1);
    check("r_count_n2", fifo_count, 0);
    wait_done();
    check("r_empty", fifo_empty, 1);

    // Fill, overflow NAK, drain across pointer wrap.
    for (int i = 1; i <= 4; i++) push_w(16'(i), 8'h06);
    check("fill_full", fifo_full, 1);
    check("fill_count", fifo_count, 4);
    push_w(16'hAABB, 8'h15);
    check("ovf_count", fifo_count, 4);
    check("ovf_full", fifo_full, 1);
    for (int i = 1; i <= 4; i++) read_w(16'(i));
    check("drain_empty", fifo_empty, 1);

    // Empty read NAK, status bytes.
    exp_q.push_back(8'h15);
    send_byte(8'h52);
    wait_done();
    exp_q.push_back(8'h40);
    send_byte(8'h53);
    check("s_start_n1", tx_start, 1);
    wait_done();
    push_w(16'h1111, 8'h06);
    push_w(16'h2222, 8'h06);
    push_w(16'h3333, 8'h06);
    exp_q.push_back(8'h03);
    send_byte(8'h53);
    wait_done();

    // Byte injected during a read response is dropped.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h11);
    d0 = drop_cnt;
    send_byte(8'h52);
    wait_q(1);
    send_byte(8'h53);
    check("rx_drop_pulse", rx_drop, 1);
    wait_done();
    check("rx_drop_count", drop_cnt, d0 + 1);
    check("drop_count_left", fifo_count, 2);

    // Flush with two words stored.
    exp_q.push_back(8'h06);
    send_byte(8'h43);
    check("c_start_n1", tx_start, 1);
    @(negedge clk);
    check("c_count_n2", fifo_count, 0);
    check("c_empty_n2", fifo_empty, 1);
    wait_done();

    // Payload timeout aborts silently.
    send_byte(8'h57); idle(2); send_byte(8'h12);
    idle(TMO + 20);
    exp_q.push_back(8'h40);
    send_byte(8'h53);
    wait_done();
    exp_q.push_back(8'h15);
    send_byte(8'h7F);
    wait_done();

    // Reset in the middle of a two-byte read response.
    push_w(16'hABCD, 8'h06);
    push_w(16'h5678, 8'h06);
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD);
    send_byte(8'h52);
    wait_q(1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_tx_start", tx_start, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_empty", fifo_empty, 1);
    rst = 1'b0;
    idle(30);
    exp_q.push_back(8'h40);
    send_byte(8'h53);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
